// File: rtl/bus_splitter.sv
// Word-to-byte re-serialiser: buffers 2-byte video words in a small FIFO and emits one byte per clock.
// Optional BUS_SPLITTER_DROP_CNT_EN adds a saturating 16-bit dropped-word counter (drop_cnt).
module bus_splitter #(
    parameter int BYTE_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                    in_clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_hsync,
    input  logic                    in_vsync,
    input  logic                    in_den,
    input  logic [2*BYTE_WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic                    out_hsync,
    output logic                    out_vsync,
    output logic                    out_den,
    output logic [BYTE_WIDTH-1:0]   out_data,
`ifdef BUS_SPLITTER_DROP_CNT_EN
    output logic [15:0]             drop_cnt,
`endif
    output logic                    overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic                    hsync;
        logic                    vsync;
        logic                    den;
        logic [2*BYTE_WIDTH-1:0] data;
    } word_t;

    typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

    word_t          mem [DEPTH];
    word_t          head, hold;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           full, push, pop, drop;
    state_t         state, state_n;

    logic                  nxt_valid, nxt_hsync, nxt_vsync, nxt_den;
    logic [BYTE_WIDTH-1:0] nxt_data;

    // Fullness is judged on the pre-edge count; a same-cycle pop never rescues a write.
    assign full     = (count == CW'(DEPTH));
    assign in_ready = ~full;
    assign push     = in_valid & ~full;
    assign drop     = in_valid & full;
    assign head     = mem[rd_ptr];

    always_ff @(posedge in_clk) begin
        if (push) mem[wr_ptr] <= word_t'{in_hsync, in_vsync, in_den, in_data};
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) overflow <= 1'b1;
        end
    end

`ifdef BUS_SPLITTER_DROP_CNT_EN
    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n)                          drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
    end
`endif

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        nxt_valid = 1'b0;
        nxt_hsync = 1'b0;
        nxt_vsync = 1'b0;
        nxt_den   = 1'b0;
        nxt_data  = '0;
        case (state)
            IDLE, SECOND: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    nxt_valid = 1'b1;
                    nxt_hsync = head.hsync;
                    nxt_vsync = head.vsync;
                    nxt_den   = head.den;
                    nxt_data  = LSB_FIRST ? head.data[BYTE_WIDTH-1:0]
                                          : head.data[2*BYTE_WIDTH-1:BYTE_WIDTH];
                    state_n   = FIRST;
                end else begin
                    state_n   = IDLE;
                end
            end
            FIRST: begin
                nxt_valid = 1'b1;
                nxt_hsync = hold.hsync;
                nxt_vsync = hold.vsync;
                nxt_den   = hold.den;
                nxt_data  = LSB_FIRST ? hold.data[2*BYTE_WIDTH-1:BYTE_WIDTH]
                                      : hold.data[BYTE_WIDTH-1:0];
                state_n   = SECOND;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            out_valid <= 1'b0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
            out_den   <= 1'b0;
            out_data  <= '0;
        end else begin
            if (pop) hold <= head;
            out_valid <= nxt_valid;
            out_hsync <= nxt_hsync;
            out_vsync <= nxt_vsync;
            out_den   <= nxt_den;
            out_data  <= nxt_data;
        end
    end
endmodule

// File: tb/tb_bus_splitter.sv
// Bench for bus_splitter: directed scenarios with literal expectations plus a randomized run
// checked against a queue-based byte-stream model.
module tb_bus_splitter;
    localparam int BW    = 8;
    localparam int DEPTH = 4;

    logic          in_clk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          in_valid = 1'b0, in_hsync = 1'b0, in_vsync = 1'b0, in_den = 1'b0;
    logic [2*BW-1:0] in_data = '0;
    logic          in_ready, out_valid, out_hsync, out_vsync, out_den, overflow;
    logic [BW-1:0] out_data;
`ifdef BUS_SPLITTER_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    int tests = 0;
    int fails = 0;

    bus_splitter #(.BYTE_WIDTH(BW), .DEPTH(DEPTH), .LSB_FIRST(1'b1)) dut (
        .in_clk(in_clk), .rst_n(rst_n), .in_valid(in_valid), .in_hsync(in_hsync),
        .in_vsync(in_vsync), .in_den(in_den), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_hsync(out_hsync), .out_vsync(out_vsync),
        .out_den(out_den), .out_data(out_data),
`ifdef BUS_SPLITTER_DROP_CNT_EN
        .drop_cnt(drop_cnt),
`endif
        .overflow(overflow)
    );

    always #5 in_clk = ~in_clk;

    // Model: a word queue plus the one pending second byte of the word being emitted.
    logic [18:0] mq[$];
    logic [18:0] held;
    bit          has_pend;
    logic [11:0] e_out;   // {valid, hsync, vsync, den, data}
    bit          e_ovf;
    int          e_drops;

    task automatic model_reset();
        mq.delete();
        has_pend = 0;
        held     = '0;
        e_out    = '0;
        e_ovf    = 0;
        e_drops  = 0;
    endtask

    task automatic model_edge();
        int pre;
        pre = mq.size();
        if (has_pend) begin
            e_out    = {1'b1, held[18:16], held[15:8]};
            has_pend = 0;
        end else if (pre > 0) begin
            held     = mq.pop_front();
            e_out    = {1'b1, held[18:16], held[7:0]};
            has_pend = 1;
        end else begin
            e_out = '0;
        end
        if (in_valid) begin
            if (pre == DEPTH) begin
                e_ovf = 1;
                if (e_drops < 65535) e_drops++;
            end else begin
                mq.push_back({in_hsync, in_vsync, in_den, in_data});
            end
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        if (!rst_n) model_reset();
        else        model_edge();
        #1;
    endtask

    task automatic drive(input bit v, input bit hs, input bit vs, input bit de, input logic [15:0] d);
        in_valid = v; in_hsync = hs; in_vsync = vs; in_den = de; in_data = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        @(negedge in_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            tests++;
            if ({out_valid, out_data, in_ready, overflow} !== {1'b0, 8'h00, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL reset_idle cyc%0d: got v=%b d=%h rdy=%b ovf=%b, want v=0 d=00 rdy=1 ovf=0",
                         i, out_valid, out_data, in_ready, overflow);
            end
        end
    endtask

    task automatic test_single();
        logic [11:0] want [3];
        want[0] = {1'b1, 3'b001, 8'h53};
        want[1] = {1'b1, 3'b001, 8'hA1};
        want[2] = 12'h000;
        drive(1, 0, 0, 1, 16'hA153);
        tick();
        drive(0, 0, 0, 0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({out_valid, out_hsync, out_vsync, out_den, out_data} !== want[i]) begin
                fails++;
                $display("FAIL single k+%0d: got %h want %h", i + 1,
                         {out_valid, out_hsync, out_vsync, out_den, out_data}, want[i]);
            end
        end
    endtask

    task automatic test_sync_replication();
        logic [11:0] want [2];
        want[0] = {1'b1, 3'b110, 8'h81};
        want[1] = {1'b1, 3'b110, 8'h23};
        drive(1, 1, 1, 0, 16'h2381);
        tick();
        drive(0, 0, 0, 0, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if ({out_valid, out_hsync, out_vsync, out_den, out_data} !== want[i]) begin
                fails++;
                $display("FAIL sync_repl byte%0d: got %h want %h", i,
                         {out_valid, out_hsync, out_vsync, out_den, out_data}, want[i]);
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_back_to_back();
        logic [15:0] words [3];
        logic [7:0]  bytes [6];
        words[0] = 16'h1008; words[1] = 16'h0375; words[2] = 16'h4537;
        bytes[0] = 8'h08; bytes[1] = 8'h10; bytes[2] = 8'h75;
        bytes[3] = 8'h03; bytes[4] = 8'h37; bytes[5] = 8'h45;
        for (int j = 0; j < 7; j++) begin
            if (j % 2 == 0 && j < 6) drive(1, 0, 0, 1, words[j/2]);
            else                     drive(0, 0, 0, 0, 16'h0000);
            tick();
            if (j >= 1) begin
                tests++;
                if ({out_valid, out_data} !== {1'b1, bytes[j-1]}) begin
                    fails++;
                    $display("FAIL b2b byte%0d: got v=%b d=%h want v=1 d=%h",
                             j - 1, out_valid, out_data, bytes[j-1]);
                end
            end
        end
        tick();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b tail: got v=%b want v=0", out_valid);
        end
        repeat (2) tick();
    endtask

    task automatic test_overflow();
        bit saw_full = 0;
        int emitted  = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 0, 1, 16'(16'h1100 + i * 16'h0101));
            tick();
            if (!in_ready) saw_full = 1;
            emitted += out_valid;
            tests++;
            if ({out_valid, out_hsync, out_vsync, out_den, out_data, in_ready} !==
                {e_out, mq.size() < DEPTH}) begin
                fails++;
                $display("FAIL ovf_fill cyc%0d: got %h rdy=%b want %h rdy=%b", i,
                         {out_valid, out_hsync, out_vsync, out_den, out_data}, in_ready,
                         e_out, mq.size() < DEPTH);
            end
        end
        drive(0, 0, 0, 0, 16'h0000);
        for (int i = 0; i < 20; i++) begin
            tick();
            emitted += out_valid;
            tests++;
            if ({out_valid, out_hsync, out_vsync, out_den, out_data} !== e_out) begin
                fails++;
                $display("FAIL ovf_drain cyc%0d: got %h want %h", i,
                         {out_valid, out_hsync, out_vsync, out_den, out_data}, e_out);
            end
        end
        tests++;
        if (!saw_full) begin fails++; $display("FAIL ovf_ready_fall: got never-low want low"); end
        tests++;
        if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        tests++;
        if (emitted != 16) begin fails++; $display("FAIL ovf_bytes: got %0d want 16", emitted); end
`ifdef BUS_SPLITTER_DROP_CNT_EN
        tests++;
        if (drop_cnt !== 16'd2) begin fails++; $display("FAIL ovf_drop_cnt: got %0d want 2", drop_cnt); end
`endif
    endtask

    task automatic test_reset_mid_word();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 1, 1, 16'(16'h7700 + i));
            tick();
        end
        drive(0, 0, 0, 0, 16'h0000);
        tests++;
        if (mq.size() != 3 || out_valid !== 1'b1) begin
            fails++;
            $display("FAIL midrst_setup: got v=%b queued=%0d want v=1 queued=3", out_valid, mq.size());
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if ({out_valid, out_hsync, out_vsync, out_den, out_data, in_ready, overflow} !== {12'h000, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL midrst_async: got v=%b d=%h rdy=%b ovf=%b want all 0, rdy=1",
                     out_valid, out_data, in_ready, overflow);
        end
        repeat (2) tick();
        @(negedge in_clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL midrst_stale cyc%0d: got v=%b d=%h want v=0", i, out_valid, out_data);
            end
        end
        drive(1, 0, 0, 1, 16'hBEEF);
        tick();
        drive(0, 0, 0, 0, 16'h0000);
        tick();
        tests++;
        if ({out_valid, out_den, out_data} !== {2'b11, 8'hEF}) begin
            fails++; $display("FAIL midrst_new_b0: got v=%b d=%h want v=1 d=ef", out_valid, out_data);
        end
        tick();
        tests++;
        if ({out_valid, out_den, out_data} !== {2'b11, 8'hBE}) begin
            fails++; $display("FAIL midrst_new_b1: got v=%b d=%h want v=1 d=be", out_valid, out_data);
        end
        repeat (2) tick();
    endtask

    task automatic test_random();
        int rate;
        for (int i = 0; i < 400; i++) begin
            rate = 20 + 27 * (i / 100);
            drive(($urandom_range(0, 99) < rate), 1'($urandom), 1'($urandom), 1'($urandom),
                  16'($urandom));
            tick();
            tests++;
            if ({out_valid, out_hsync, out_vsync, out_den, out_data, in_ready, overflow} !==
                {e_out, mq.size() < DEPTH, e_ovf}) begin
                fails++;
                $display("FAIL random cyc%0d: got %h rdy=%b ovf=%b want %h rdy=%b ovf=%b", i,
                         {out_valid, out_hsync, out_vsync, out_den, out_data}, in_ready, overflow,
                         e_out, mq.size() < DEPTH, e_ovf);
            end
`ifdef BUS_SPLITTER_DROP_CNT_EN
            tests++;
            if (drop_cnt !== 16'(e_drops)) begin
                fails++;
                $display("FAIL random_drop_cnt cyc%0d: got %0d want %0d", i, drop_cnt, e_drops);
            end
`endif
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_sync_replication();
        test_back_to_back();
        test_overflow();
        test_reset_mid_word();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
